// File: rtl/pad_bscan_pkg.sv
// Shared types and helpers for the pad boundary-scan sequencer.
//   state_e       : sequencer states
//   CELL_*        : bit layout of one pad cell in the scan/update registers
//   clamp_settle  : lower-bounds the settle time to 2 clocks
package pad_bscan_pkg;

    typedef enum logic [2:0] {
        FUNC    = 3'd0,
        ENTER   = 3'd1,
        HOLD    = 3'd2,
        UPDATE  = 3'd3,
        SETTLE  = 3'd4,
        CAPTURE = 3'd5,
        EXIT    = 3'd6
    } state_e;

    localparam int CELL_DO = 0;
    localparam int CELL_OE = 1;
    localparam int CELL_W  = 2;

    function automatic int clamp_settle(input int cyc);
        return (cyc < 2) ? 2 : cyc;
    endfunction

endpackage

// File: rtl/pad_bscan_sync2.sv
// Single-bit two-flop synchronizer for asynchronous pad inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (both flops clear to 0)
//   d_i    : asynchronous input
//   q_o    : synchronized output
module pad_bscan_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pad_bscan_ctrl.sv
// Boundary-scan sequencer for a bank of open-drain pads.
// Functional mode passes func_* to pad_*. Scan mode drives the pads from an
// update register loaded out of a serial shift register, waits SETTLE_CYC
// clocks for pull-ups, then captures synchronized pad inputs back into the
// shift register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   func_do/oen/ie/ren  : core pad controls (passthrough in functional mode)
//   pad_do/oen/ie/ren   : pad controls; pad_bsen selects scan on all pads
//   pad_di              : asynchronous pad readback
//   enter/run/exit_req  : single-cycle command pulses
//   shift_en, sdi, sdo  : serial access to the 2*NPADS-bit shift register
//   busy, done          : sequencer status; done pulses in CAPTURE
//   mismatch(_any)      : capture compare result
// Optional feature macro: PAD_BSCAN_CMP_EN enables the capture compare;
// without it mismatch and mismatch_any are tied to 0.
module pad_bscan_ctrl
    import pad_bscan_pkg::*;
#(
    parameter int NPADS      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPADS-1:0] func_do,
    input  logic [NPADS-1:0] func_oen,
    input  logic [NPADS-1:0] func_ie,
    input  logic [NPADS-1:0] func_ren,
    output logic [NPADS-1:0] pad_do,
    output logic [NPADS-1:0] pad_oen,
    output logic [NPADS-1:0] pad_ie,
    output logic [NPADS-1:0] pad_ren,
    output logic             pad_bsen,
    input  logic [NPADS-1:0] pad_di,
    input  logic             enter_req,
    input  logic             run_req,
    input  logic             exit_req,
    input  logic             shift_en,
    input  logic             sdi,
    output logic             sdo,
    output logic             busy,
    output logic             done,
    output logic [NPADS-1:0] mismatch,
    output logic             mismatch_any
);

    localparam int            SC       = clamp_settle(SETTLE_CYC);
    localparam int            CW       = $clog2(SC);
    localparam int            SRW      = CELL_W * NPADS;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SC - 1);

    state_e           state_q, state_d;
    logic [SRW-1:0]   sr_q, sr_d;
    logic [SRW-1:0]   ur_q, ur_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NPADS-1:0] di_s;
    logic [NPADS-1:0] ur_do;
    logic [NPADS-1:0] ur_oe;

    for (genvar g = 0; g < NPADS; g++) begin : g_sync
        pad_bscan_sync2 u_sync (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .d_i    (pad_di[g]),
            .q_o    (di_s[g])
        );
    end

    always_comb begin
        ur_do = '0;
        ur_oe = '0;
        for (int i = 0; i < NPADS; i++) begin
            ur_do[i] = ur_q[CELL_W*i + CELL_DO];
            ur_oe[i] = ur_q[CELL_W*i + CELL_OE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FUNC;
            sr_q    <= '0;
            ur_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            ur_q    <= ur_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        ur_d    = ur_q;
        cnt_d   = cnt_q;
        case (state_q)
            FUNC: begin
                if (enter_req) state_d = ENTER;
            end
            ENTER: begin
                ur_d    = '0;
                state_d = HOLD;
            end
            HOLD: begin
                // A run request takes priority over both exit and shift.
                if (run_req) begin
                    state_d = UPDATE;
                end else begin
                    if (shift_en) sr_d = {sdi, sr_q[SRW-1:1]};
                    if (exit_req) state_d = EXIT;
                end
            end
            UPDATE: begin
                ur_d    = sr_q;
                cnt_d   = CNT_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            CAPTURE: begin
                // Only the data bits take the pad readback; enables are kept.
                for (int i = 0; i < NPADS; i++) sr_d[CELL_W*i + CELL_DO] = di_s[i];
                state_d = HOLD;
            end
            EXIT: begin
                state_d = FUNC;
            end
            default: begin
                state_d = FUNC;
            end
        endcase
    end

    // Pad controls decode straight from the state register so that an
    // asynchronous reset drops pad_bsen without waiting for a clock.
    always_comb begin
        pad_do   = func_do;
        pad_oen  = func_oen;
        pad_ie   = func_ie;
        pad_ren  = func_ren;
        pad_bsen = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ENTER, EXIT: begin
                pad_do   = '0;
                pad_oen  = '1;
                pad_ie   = '1;
                pad_ren  = '0;
                pad_bsen = 1'b1;
                busy     = 1'b1;
            end
            HOLD, UPDATE, SETTLE, CAPTURE: begin
                pad_do   = ur_do;
                pad_oen  = ~ur_oe;
                pad_ie   = '1;
                pad_ren  = '0;
                pad_bsen = 1'b1;
                busy     = (state_q != HOLD);
                done     = (state_q == CAPTURE);
            end
            default: begin
            end
        endcase
    end

    assign sdo = sr_q[0];

`ifdef PAD_BSCAN_CMP_EN
    logic [NPADS-1:0] mm_q, mm_d;
    logic             mm_any_q, mm_any_d;
    logic [NPADS-1:0] mm_new;

    // A driven pad whose readback differs from its drive value is a fault.
    assign mm_new = ur_oe & (di_s ^ ur_do);

    always_comb begin
        mm_d     = mm_q;
        mm_any_d = mm_any_q;
        if (state_q == ENTER) begin
            mm_d     = '0;
            mm_any_d = 1'b0;
        end else if (state_q == CAPTURE) begin
            mm_d     = mm_new;
            mm_any_d = |mm_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_q     <= '0;
            mm_any_q <= 1'b0;
        end else begin
            mm_q     <= mm_d;
            mm_any_q <= mm_any_d;
        end
    end

    assign mismatch     = mm_q;
    assign mismatch_any = mm_any_q;
`else
    assign mismatch     = '0;
    assign mismatch_any = 1'b0;
`endif

endmodule

// File: tb/tb_pad_bscan_ctrl.sv
// Bench for pad_bscan_ctrl (NPADS=8, SETTLE_CYC=4) with a transaction-level
// model, a per-cycle compare process and directed literal expectations.
module tb_pad_bscan_ctrl;

    localparam int NP = 8;
    localparam int SC = 4;
`ifdef PAD_BSCAN_CMP_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] func_do, func_oen, func_ie, func_ren;
    logic [NP-1:0] pad_do, pad_oen, pad_ie, pad_ren;
    logic          pad_bsen;
    logic [NP-1:0] pad_di;
    logic          enter_req, run_req, exit_req, shift_en, sdi;
    logic          sdo, busy, done;
    logic [NP-1:0] mismatch;
    logic          mismatch_any;
    logic [NP-1:0] stuck;

    int n_tests = 0;
    int n_fail  = 0;

    pad_bscan_ctrl #(.NPADS(NP), .SETTLE_CYC(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .func_do      (func_do),
        .func_oen     (func_oen),
        .func_ie      (func_ie),
        .func_ren     (func_ren),
        .pad_do       (pad_do),
        .pad_oen      (pad_oen),
        .pad_ie       (pad_ie),
        .pad_ren      (pad_ren),
        .pad_bsen     (pad_bsen),
        .pad_di       (pad_di),
        .enter_req    (enter_req),
        .run_req      (run_req),
        .exit_req     (exit_req),
        .shift_en     (shift_en),
        .sdi          (sdi),
        .sdo          (sdo),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_any (mismatch_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Open-drain pad with pull-up: reads 0 only when actively driven low,
    // or when a stuck-low fault is injected.
    assign pad_di = ~(~pad_oen & ~pad_do) & ~stuck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: functional, entering, idle in scan, running (age counts clocks
    // since the run was accepted), exiting.
    localparam int P_FUNC = 0, P_ENTER = 1, P_HOLD = 2, P_RUN = 3, P_EXIT = 4;
    int            m_ph;
    int            m_age;
    logic [15:0]   m_sr;
    logic [NP-1:0] m_do, m_oe, m_s1, m_s2, m_mm;
    logic          m_mm_any;
    logic [NP-1:0] e_do, e_oen, e_ie, e_ren, m_di, sr_do, sr_oe;
    logic          e_bsen, e_busy, e_done;
    logic [15:0]   m_cap;

    always_comb begin
        e_do = func_do; e_oen = func_oen; e_ie = func_ie; e_ren = func_ren;
        e_bsen = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_ph == P_ENTER || m_ph == P_EXIT) begin
            e_do = '0; e_oen = '1; e_ie = '1; e_ren = '0; e_bsen = 1'b1; e_busy = 1'b1;
        end else if (m_ph == P_HOLD || m_ph == P_RUN) begin
            e_do = m_do; e_oen = ~m_oe; e_ie = '1; e_ren = '0; e_bsen = 1'b1;
            e_busy = (m_ph == P_RUN);
            e_done = (m_ph == P_RUN) && (m_age == SC + 1);
        end
        m_di  = ~(~e_oen & ~e_do) & ~stuck;
        sr_do = '0; sr_oe = '0;
        m_cap = m_sr;
        for (int i = 0; i < NP; i++) begin
            sr_do[i]    = m_sr[2*i];
            sr_oe[i]    = m_sr[2*i+1];
            m_cap[2*i]  = m_s2[i];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= P_FUNC; m_age <= 0; m_sr <= '0; m_do <= '0; m_oe <= '0;
            m_s1 <= '0; m_s2 <= '0; m_mm <= '0; m_mm_any <= 1'b0;
        end else begin
            m_s1 <= m_di;
            m_s2 <= m_s1;
            case (m_ph)
                P_FUNC:  if (enter_req) m_ph <= P_ENTER;
                P_ENTER: begin m_do <= '0; m_oe <= '0; m_mm <= '0; m_mm_any <= 1'b0; m_ph <= P_HOLD; end
                P_HOLD: begin
                    if (run_req) begin
                        m_ph <= P_RUN; m_age <= 0;
                    end else begin
                        if (shift_en) m_sr <= {sdi, m_sr[15:1]};
                        if (exit_req) m_ph <= P_EXIT;
                    end
                end
                P_RUN: begin
                    if (m_age == 0) begin m_do <= sr_do; m_oe <= sr_oe; end
                    if (m_age == SC + 1) begin
                        m_sr     <= m_cap;
                        m_mm     <= m_oe & (m_s2 ^ m_do);
                        m_mm_any <= |(m_oe & (m_s2 ^ m_do));
                        m_ph     <= P_HOLD;
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
                default: m_ph <= P_FUNC;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_pad_do",   pad_do,   e_do);
            chk("cyc_pad_oen",  pad_oen,  e_oen);
            chk("cyc_pad_ie",   pad_ie,   e_ie);
            chk("cyc_pad_ren",  pad_ren,  e_ren);
            chk("cyc_pad_bsen", pad_bsen, e_bsen);
            chk("cyc_busy",     busy,     e_busy);
            chk("cyc_done",     done,     e_done);
            chk("cyc_sdo",      sdo,      m_sr[0]);
            chk("cyc_mismatch", mismatch, CMP_ON ? m_mm : 8'h00);
            chk("cyc_mm_any",   mismatch_any, CMP_ON ? m_mm_any : 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter; enter_req = 1'b1; tick; enter_req = 1'b0; endtask
    task automatic pulse_exit;  exit_req  = 1'b1; tick; exit_req  = 1'b0; endtask

    task automatic shift_in(input logic [15:0] v);
        for (int b = 0; b < 16; b++) begin
            sdi = v[b]; shift_en = 1'b1; tick;
        end
        shift_en = 1'b0; sdi = 1'b0;
    endtask

    task automatic read_sr(output logic [15:0] rd);
        for (int b = 0; b < 16; b++) begin
            rd[b] = sdo; sdi = 1'b0; shift_en = 1'b1; tick;
        end
        shift_en = 1'b0;
    endtask

    // Returns clocks from the run_req cycle to the cycle done is seen.
    task automatic run_wait(input bit poke, output int cyc);
        run_req = 1'b1; tick; run_req = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (poke && cyc == 3) begin
                chk("settle_pad_do",  pad_do,  8'hF7);
                chk("settle_pad_oen", pad_oen, 8'h00);
                sdi = 1'b1; shift_en = 1'b1;
            end
            tick;
            shift_en = 1'b0; sdi = 1'b0;
            cyc++;
        end
    endtask

    function automatic logic [7:0] do_field(input logic [15:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[2*i];
        return r;
    endfunction

    function automatic logic [7:0] oe_field(input logic [15:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    logic [15:0] tgt;
    logic [15:0] rd;
    int          lat;

    initial begin
        rst_n = 1'b0; enter_req = 1'b0; run_req = 1'b0; exit_req = 1'b0;
        shift_en = 1'b0; sdi = 1'b0; stuck = '0;
        func_do = 8'h5A; func_oen = 8'hF0; func_ie = 8'h0F; func_ren = 8'h33;
        for (int i = 0; i < 8; i++) begin
            tgt[2*i]   = (i != 3);
            tgt[2*i+1] = 1'b1;
        end
        tick; tick;
        chk("rst_pad_do",   pad_do,   8'h5A);
        chk("rst_pad_oen",  pad_oen,  8'hF0);
        chk("rst_pad_bsen", pad_bsen, 1'b0);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_done",     done,     1'b0);
        chk("rst_sdo",      sdo,      1'b0);
        chk("rst_mismatch", mismatch, 8'h00);
        rst_n = 1'b1;
        tick;
        chk("func_pad_do",  pad_do,  8'h5A);
        chk("func_pad_oen", pad_oen, 8'hF0);

        // Enter scan mode
        pulse_enter;
        chk("enter_oen",  pad_oen,  8'hFF);
        chk("enter_bsen", pad_bsen, 1'b1);
        chk("enter_busy", busy,     1'b1);
        tick;
        pulse_enter;
        chk("hold_ignores_enter", busy, 1'b0);

        // Shift pattern, run, shift back out
        shift_in(tgt);
        run_wait(1'b1, lat);
        chk("run_latency", lat, 6);
        tick;
        read_sr(rd);
        chk("readback_do", do_field(rd), 8'hF7);
        chk("readback_oe", oe_field(rd), 8'hFF);

        // Stuck-low pad 5
        stuck = 8'h20;
        shift_in(tgt);
        run_wait(1'b0, lat);
        chk("stuck_latency", lat, 6);
        tick;
        chk("stuck_mismatch", mismatch,     CMP_ON ? 8'h20 : 8'h00);
        chk("stuck_mm_any",   mismatch_any, CMP_ON ? 1'b1 : 1'b0);
        read_sr(rd);
        chk("stuck_readback_do", do_field(rd), 8'hD7);
        stuck = '0;

        // Run and exit together: run wins, back to HOLD
        run_req = 1'b1; exit_req = 1'b1; tick; run_req = 1'b0; exit_req = 1'b0;
        chk("arb_busy_update", busy, 1'b1);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin tick; lat++; end
        chk("arb_latency", lat, 6);
        tick;
        chk("arb_in_hold_busy", busy,     1'b0);
        chk("arb_in_hold_bsen", pad_bsen, 1'b1);

        // Exit
        pulse_exit;
        chk("exit_oen",  pad_oen,  8'hFF);
        chk("exit_bsen", pad_bsen, 1'b1);
        tick;
        chk("post_exit_do",   pad_do,   8'h5A);
        chk("post_exit_bsen", pad_bsen, 1'b0);

        // Reset in the middle of SETTLE
        pulse_enter;
        tick;
        shift_in(tgt);
        chk("pre_rst_sdo", sdo, 1'b1);
        run_req = 1'b1; tick; run_req = 1'b0;
        tick; tick;
        chk("mid_settle_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bsen", pad_bsen, 1'b0);
        chk("async_rst_sdo",  sdo,      1'b0);
        chk("async_rst_oen",  pad_oen,  8'hF0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("after_rst_busy", busy,     1'b0);
        chk("after_rst_bsen", pad_bsen, 1'b0);
        chk("after_rst_sdo",  sdo,      1'b0);
        chk("after_rst_do",   pad_do,   8'h5A);
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pad_bscan_ctrl.md
Name: pad_bscan_ctrl

Overview:
Boundary-scan sequencer for a bank of NPADS open-drain SB_IO-style pads with BSEN/IE/REN controls. In functional mode it passes core pad controls straight through. In scan mode it takes the pads away from the core and applies a serially loaded drive pattern. It then waits for the weak pull-ups to settle and captures the synchronized pad inputs back into the shift register. Sits between the core IO logic, the pad ring and a test host (JTAG TAP or SPI debug port).

Parameters:
NPADS, 8, number of pads controlled (1..32)
SETTLE_CYC, 16, clocks from UPDATE to CAPTURE; covers pull-up rise time; values below 2 are clamped to 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
func_do  in  NPADS  core drive data
func_oen  in  NPADS  core output enable, active-low
func_ie  in  NPADS  core input enable
func_ren  in  NPADS  core pull-up enable, active-low
pad_do  out  NPADS  to pad DO
pad_oen  out  NPADS  to pad OEN
pad_ie  out  NPADS  to pad IE
pad_ren  out  NPADS  to pad REN
pad_bsen  out  1  to all pad BSEN
pad_di  in  NPADS  from pad DI, asynchronous
enter_req  in  1  pulse: enter scan mode
run_req  in  1  pulse: update/settle/capture cycle
exit_req  in  1  pulse: leave scan mode
shift_en  in  1  shift scan register one bit
sdi  in  1  serial data in
sdo  out  1  serial data out
busy  out  1  high in ENTER, UPDATE, SETTLE, CAPTURE and EXIT
done  out  1  one-cycle pulse at end of CAPTURE
mismatch  out  NPADS  per-pad compare fail (see Optional Feature)
mismatch_any  out  1  OR of mismatch

Behaviour:
- Reset values:
  - state FUNC; all outputs 0 except pad_* passthrough.
  - shift register sr (2*NPADS bits) = 0; update register ur = 0, which means all pads released.
  - pad_di synchronizer flops = 0.
- Cell i in sr and ur:
  - bit 2i = do_i; bit 2i+1 = oe_i (1 = drive).
  - Shift direction is toward the LSB: sdo = sr[0]; on shift, sr <= {sdi, sr[2N-1:1]}.
- Scan-mode pad drive, applied in UPDATE, SETTLE, CAPTURE and HOLD:
  - pad_do = ur.do; pad_oen = ~ur.oe; pad_ie = 1; pad_ren = 0 (pull-ups on); pad_bsen = 1.
- pad_di goes through a 2-flop synchronizer (di_s) before use.
- FSM states:
  - FUNC: pad_* = func_*; pad_bsen = 0. enter_req -> ENTER. run_req, exit_req and shift_en are ignored.
  - ENTER (1 cycle): pad_bsen = 1; pad_oen all 1; pad_ie = 1; pad_ren = 0; ur cleared -> HOLD.
  - HOLD: pads driven from ur. shift_en shifts sr.
    - run_req -> UPDATE.
    - exit_req -> EXIT.
    - run_req with exit_req: run wins, exit is dropped.
    - run_req with shift_en: run wins, no shift that cycle.
  - UPDATE (1 cycle): ur <= sr; counter <= SETTLE_CYC-1 -> SETTLE.
  - SETTLE: counter decrements each clock; shift_en ignored; at 0 -> CAPTURE.
  - CAPTURE (1 cycle): sr.do bits <= di_s; sr.oe bits unchanged; done = 1 -> HOLD.
  - EXIT (1 cycle): pad_oen all 1; pad_bsen = 1 -> FUNC. From the next cycle pads follow func_*.
- Latency:
  - run_req to done is 2 + SETTLE_CYC clocks.
  - First pad change is 1 clock after UPDATE.
- Requests arriving in non-HOLD/FUNC states are dropped, not queued.
- Reset asserted mid-operation: immediate return to FUNC; pad_bsen deasserts asynchronously; sr and ur cleared.
- Counter width is clog2(SETTLE_CYC). SETTLE_CYC = 1 behaves as 2.

Optional Feature:
- Macro: PAD_BSCAN_CMP_EN.
- Defined:
  - In CAPTURE, mismatch[i] <= ur.oe_i & (di_s[i] != ur.do_i).
  - mismatch_any is the registered OR of the new mismatch vector.
  - Both hold until the next CAPTURE or reset. ENTER clears them.
  - Catches pads stuck low (do=1 released but reads 0) and pads that fail to pull down.
- Undefined: mismatch and mismatch_any are tied to 0; no compare logic is synthesized.

Decomposition:
- Package pad_bscan_pkg holds:
  - state enum (FUNC, ENTER, HOLD, UPDATE, SETTLE, CAPTURE, EXIT)
  - cell bit offsets CELL_DO = 0, CELL_OE = 1, CELL_W = 2
  - clamp function for SETTLE_CYC
- One sub-module, pad_bscan_sync2: per-bit 2-flop synchronizer with async active-low reset, instantiated NPADS wide.

Test Plan:
- Reset/passthrough: NPADS=8; func_oen=8'hF0, func_do=8'h5A -> pad_oen=8'hF0, pad_do=8'h5A, pad_bsen=0, busy=0.
- Enter, shift, run (pad_di models open-drain with pull-up, SETTLE_CYC=4):
  - Stimulus: enter_req, shift 16 bits so every cell = oe 1, do 1 except pad 3 (do 0), then run_req.
  - Required: pad_oen=8'h00; pad_do=8'hF7; done exactly 6 clocks after run_req.
  - Then shifting out 16 bits returns do field 8'hF7.
- Stuck-low fault: same as above, with pad_di[5] forced 0 -> with PAD_BSCAN_CMP_EN: mismatch=8'h20 and mismatch_any=1 after done; without the macro both stay 0.
- Arbitration:
  - run_req and exit_req together in HOLD -> UPDATE taken, state returns to HOLD.
  - shift_en during SETTLE -> sr unchanged.
  - enter_req while in HOLD -> ignored.
- Exit: exit_req in HOLD -> 1 cycle with pad_oen=8'hFF and pad_bsen=1, then pads equal func_*, pad_bsen=0.
- Reset mid-SETTLE: rst_n low at counter=2 -> pad_bsen=0 within the same cycle, sr=0; after release, state is FUNC and sdo=0.
